// File: rtl/led_ctrl.sv
// Memory-mapped LED/status controller: per-channel off/on/blink/PWM modes and a prescaler heartbeat.
// Optional PWM dimming (duty storage and comparator) is built only when LED_CTRL_PWM_EN is defined.
module led_ctrl #(
  parameter int          N_CH      = 8,
  parameter int          DIV_W     = 25,
  parameter int          PWM_W     = 4,
  parameter logic [15:0] BASE_ADDR = 16'hFFE0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wen,
  input  logic [15:0]      waddr,
  input  logic [15:0]      wdata,
  input  logic             ren,
  input  logic [15:0]      raddr,
  output logic [15:0]      rdata,
  output logic [N_CH-1:0]  leds,
  output logic             status_led
);

  localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [1:0]       mode_q [N_CH];
  logic [3:0]       rate_q [N_CH];
`ifdef LED_CTRL_PWM_EN
  logic [PWM_W-1:0] duty_q [N_CH];
  logic [PWM_W-1:0] pcnt;
`endif
  logic [DIV_W-1:0] presc;

  logic [15:0]      woff, roff;
  logic             wr_hit, rd_in;
  logic [AW-1:0]    widx, ridx;
  logic [15:0]      rd_word;
  logic [N_CH-1:0]  leds_d;
  logic             unused_wdata;

  // Offsets wrap modulo 2^16, so addresses below BASE_ADDR land far out of range.
  assign woff   = waddr - BASE_ADDR;
  assign roff   = raddr - BASE_ADDR;
  assign wr_hit = wen && (woff < 16'(N_CH));
  assign rd_in  = roff < 16'(N_CH);
  assign widx   = woff[AW-1:0];
  assign ridx   = roff[AW-1:0];
  assign unused_wdata = ^{wdata[15:12], wdata[7:2], woff, roff};

  function automatic logic blink_bit(input logic [DIV_W-1:0] p, input logic [3:0] r);
    int               idx;
    logic [DIV_W-1:0] sh;
    idx = DIV_W - 1 - int'(r);
    if (idx < 0) idx = 0;
    sh = p >> idx;
    return sh[0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= '0;
        rate_q[i] <= '0;
`ifdef LED_CTRL_PWM_EN
        duty_q[i] <= '0;
`endif
      end
    end else if (wr_hit) begin
      mode_q[widx] <= wdata[1:0];
      rate_q[widx] <= wdata[11:8];
`ifdef LED_CTRL_PWM_EN
      duty_q[widx] <= wdata[4 +: PWM_W];
`endif
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word[1:0]  = mode_q[ridx];
      rd_word[11:8] = rate_q[ridx];
`ifdef LED_CTRL_PWM_EN
      rd_word[4 +: PWM_W] = duty_q[ridx];
`endif
    end
  end

`ifdef LED_CTRL_PWM_EN
  assign pcnt = presc[PWM_W-1:0];
`endif

  always_comb begin
    leds_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode_q[i])
        2'd0: leds_d[i] = 1'b0;
        2'd1: leds_d[i] = 1'b1;
        2'd2: leds_d[i] = blink_bit(presc, rate_q[i]);
`ifdef LED_CTRL_PWM_EN
        // Full-scale duty is forced on so the top code really means 100%.
        default: leds_d[i] = (duty_q[i] == '1) || (pcnt < duty_q[i]);
`else
        default: leds_d[i] = 1'b1;
`endif
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      leds       <= '0;
      rdata      <= '0;
      status_led <= 1'b0;
    end else begin
      presc      <= presc + 1'b1;
      leds       <= leds_d;
      status_led <= presc[DIV_W-1];
      if (ren) rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl (DIV_W=8, PWM_W=4, N_CH=8): cycle-level reference model compared every cycle,
// plus directed literal checks of reset, heartbeat, readback, blink periods and PWM duty.
module tb_led_ctrl;
  localparam logic [15:0] BASE = 16'hFFE0;
`ifdef LED_CTRL_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif
  localparam logic [15:0] MASK = PWM ? 16'h0FF3 : 16'h0F03;

  logic clk = 1'b0, reset = 1'b1;
  logic wen = 1'b0, ren = 1'b0;
  logic [15:0] waddr = '0, wdata = '0, raddr = '0;
  logic [15:0] rdata;
  logic [7:0]  leds;
  logic        status_led;

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 1'b0;

  led_ctrl #(.N_CH(8), .DIV_W(8), .PWM_W(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata), .leds(leds), .status_led(status_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: registers as masked words, prescaler as a plain cycle count.
  logic [15:0] mreg [8];
  int          mcnt;
  logic [7:0]  m_leds;
  logic        m_status;
  logic [15:0] m_rdata;

  function automatic bit in_rng(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return off < 16'd8;
  endfunction

  function automatic logic led_of(input logic [15:0] r, input int cnt);
    int mode, rate, duty, idx;
    mode = int'(r & 16'h3);
    rate = int'((r >> 8) & 16'hF);
    duty = int'((r >> 4) & 16'hF);
    idx  = 7 - rate;
    if (idx < 0) idx = 0;
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ((cnt >> idx) & 1) != 0;
      default: begin
        if (!PWM) return 1'b1;
        if (duty == 15) return 1'b1;
        return (cnt % 16) < duty;
      end
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mreg[i] <= '0;
      mcnt <= 0; m_leds <= '0; m_status <= 1'b0; m_rdata <= '0;
    end else begin
      for (int i = 0; i < 8; i++) m_leds[i] <= led_of(mreg[i], mcnt);
      m_status <= ((mcnt >> 7) & 1) != 0;
      if (ren) m_rdata <= in_rng(raddr) ? mreg[3'(raddr - BASE)] : 16'h0;
      if (wen && in_rng(waddr)) mreg[3'(waddr - BASE)] <= wdata & MASK;
      mcnt <= (mcnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("model_leds", {8'h0, leds}, {8'h0, m_leds});
      chk("model_status", {15'h0, status_led}, {15'h0, m_status});
      chk("model_rdata", rdata, m_rdata);
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); wen = 1'b1; waddr = a; wdata = d;
    @(negedge clk); wen = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk); ren = 1'b1; raddr = a;
    @(posedge clk); #1;
    chk(nm, rdata, exp);
    ren = 1'b0;
  endtask

  task automatic count_toggles(input int ch, input int n, output int t);
    logic prev;
    t = 0;
    @(posedge clk); #1 prev = leds[ch];
    repeat (n) begin
      @(posedge clk); #1;
      if (leds[ch] != prev) t++;
      prev = leds[ch];
    end
  endtask

  task automatic count_high(input int ch, output int c);
    c = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (leds[ch]) c++;
    end
  endtask

  int t;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset mid-operation with channel 0 on and a nonzero read result
    wr(BASE, 16'h0001);
    rd("rd_ch0_on", BASE, 16'h0001);
    repeat (3) @(posedge clk);
    #1 chk("ch0_on", {15'h0, leds[0]}, 16'h1);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("rst_leds", {8'h0, leds}, 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_status", {15'h0, status_led}, 16'h0);
    wen = 1'b1; waddr = BASE + 16'd3; wdata = 16'h0001; ren = 1'b1; raddr = BASE;
    @(posedge clk);
    #1 wen = 1'b0; ren = 1'b0;
    @(negedge clk) reset = 1'b0;

    // Heartbeat: rises at edge 129, falls at edge 257 after release
    @(posedge clk); #1;
    chk("post_rst_leds", {8'h0, leds}, 16'h0);
    repeat (127) @(posedge clk);
    #1 chk("hb_128", {15'h0, status_led}, 16'h0);
    @(posedge clk); #1 chk("hb_129", {15'h0, status_led}, 16'h1);
    repeat (127) @(posedge clk);
    #1 chk("hb_256", {15'h0, status_led}, 16'h1);
    @(posedge clk); #1 chk("hb_257", {15'h0, status_led}, 16'h0);
    rd("rd_ch3_discarded", BASE + 16'd3, 16'h0000);

    // Write/read channel 2, out-of-range accesses
    wr(BASE + 16'd2, 16'h0B71);
    @(posedge clk); #1 chk("leds2_after_wr", {15'h0, leds[2]}, 16'h1);
    rd("rd_ch2", BASE + 16'd2, PWM ? 16'h0B71 : 16'h0B01);
    wr(BASE + 16'd8, 16'h0001);
    wr(BASE - 16'd1, 16'h0001);
    rd("rd_oor_hi", BASE + 16'd8, 16'h0000);
    rd("rd_ch7", BASE + 16'd7, 16'h0000);

    // Same-cycle read and write of channel 0
    wr(BASE, 16'h0001);
    @(negedge clk);
    wen = 1'b1; waddr = BASE; wdata = 16'h0002; ren = 1'b1; raddr = BASE;
    @(posedge clk); #1 chk("rw_same_old", rdata, 16'h0001);
    wen = 1'b0; ren = 1'b0;
    rd("rw_same_new", BASE, 16'h0002);

    // Blink on channel 1
    wr(BASE + 16'd1, 16'h0002);
    count_toggles(1, 256, t);
    chk("blink_rate0", 16'(t), 16'd2);
    wr(BASE + 16'd1, 16'h0302);
    count_toggles(1, 64, t);
    chk("blink_rate3", 16'(t), 16'd4);
    wr(BASE + 16'd1, 16'h0902);
    count_toggles(1, 16, t);
    chk("blink_rate9", 16'(t), 16'd16);

    // PWM on channel 0
    wr(BASE, 16'h0043);
    count_high(0, t);
    chk("pwm_duty4", 16'(t), PWM ? 16'd4 : 16'd16);
    rd("rd_pwm_duty4", BASE, PWM ? 16'h0043 : 16'h0003);
    wr(BASE, 16'h0003);
    count_high(0, t);
    chk("pwm_duty0", 16'(t), PWM ? 16'd0 : 16'd16);
    wr(BASE, 16'h00F3);
    count_high(0, t);
    chk("pwm_duty15", 16'(t), 16'd16);
    repeat (300) @(posedge clk);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/led_ctrl.md
# led_ctrl

Parametrised, memory-mapped LED/status controller that replaces the fixed status-blink counter and the raw `ret_val` LED wiring in the `jpeb` top level. It sits on the CPU's memory write/read port alongside `mem`. It provides N independent LED channels, each with its own mode: off, on, blink at a selectable rate, or PWM dimming. It also drives the heartbeat `status_led` from a shared free-running prescaler.

## Interface
Parameters:
- `N_CH`, 8, number of LED channels (1–16)
- `DIV_W`, 25, prescaler width; heartbeat = prescaler MSB
- `PWM_W`, 4, PWM duty resolution in bits (1–4)
- `BASE_ADDR`, 16'hFFE0, word address of channel 0 register

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wen` in 1: write strobe, sampled on `posedge clk`.
- `waddr` in 16: write word address.
- `wdata` in 16: write data.
- `ren` in 1: read strobe.
- `raddr` in 16: read word address.
- `rdata` out 16: registered read data.
- `leds` out N_CH: registered LED outputs.
- `status_led` out 1: heartbeat, prescaler bit DIV_W-1.

## Operation
- Channel register `ch` lives at `BASE_ADDR + ch`, for ch in 0..N_CH-1. Field layout:
  - [1:0] mode: 0 off, 1 on, 2 blink, 3 PWM.
  - [7:4] duty; only the low PWM_W bits are stored.
  - [11:8] rate.
  - All other bits are not stored and read as 0.
- Prescaler: DIV_W-bit counter that increments by 1 every cycle and wraps from all-ones to 0.
- Blink: the output follows prescaler bit `DIV_W-1-rate`. If that index is below 0, bit 0 is used. Rate 0 therefore gives the slowest blink, equal to the heartbeat.
- PWM: `pcnt` = prescaler[PWM_W-1:0]. The output is 1 when duty == all-ones, otherwise when `pcnt < duty`. Duty 0 is always off.
- Write: when `wen` is high and `waddr` is in range, the addressed register is updated. Writes to out-of-range addresses are ignored.
- Read: when `ren` is high, `rdata` is updated with the addressed register, or 0 if out of range. When `ren` is low, `rdata` holds its value.
- Simultaneous read and write of the same register: the read returns the pre-write value.

## Timing
- Reset (asynchronous, immediate): all registers 0, prescaler 0, `leds` 0, `rdata` 0, `status_led` 0.
- After reset is released, the prescaler increments from the first `posedge clk`.
- A write at edge k changes the register at edge k. `leds` reflects the new mode at edge k+1, giving 1-cycle write-to-LED latency.
- Read latency: 1 cycle; `rdata` is valid after the `posedge` at which `ren` was sampled.
- `leds[ch]` at edge k+1 is computed from the register and prescaler values present after edge k.
- `status_led` is a registered copy of the prescaler MSB, so it lags the prescaler by 1 cycle.
- Prescaler wrap: there is no glitch. Blink and PWM outputs follow the wrapped value continuously.
- Reset asserted mid-operation: outputs clear immediately. Pending reads and writes in that cycle are discarded.

## Configuration
- `LED_CTRL_PWM_EN` defined:
  - PWM mode is implemented.
  - Duty bits are stored and readable.
- `LED_CTRL_PWM_EN` undefined:
  - No duty storage and no PWM comparator.
  - Mode 3 behaves exactly as mode 1 (on).
  - Duty field reads as 0.

## Test plan
- Reset: hold `reset`=1 mid-count with mode 1 on channel 0 → `leds`=0, `rdata`=0, `status_led`=0 immediately. After release the prescaler restarts at 0.
- Write/read: write 16'h0B71 to BASE_ADDR+2, then read it back → `rdata`=16'h0B71 one cycle after `ren`. `leds[2]`=1 one cycle after the write. Reading BASE_ADDR+N_CH returns 0.
- Blink: DIV_W=8, channel 1 mode 2 with rate 0 → `leds[1]` toggles every 128 cycles. With rate 3 it toggles every 16 cycles. With rate 9 (clamped to bit 0) it toggles every cycle.
- PWM (macro defined): PWM_W=4, duty 4 → `leds[0]` high for 4 of every 16 cycles. Duty 0 → always 0. Duty 15 → always 1.
  - Macro undefined: mode 3 with duty 4 → always 1, and duty reads back 0.
- Same-cycle read/write to BASE_ADDR: old value 16'h0001, write 16'h0002 → `rdata`=16'h0001, and the next read returns 16'h0002.
- Heartbeat wrap: DIV_W=8 → `status_led` rises at cycle 129 and falls at cycle 257 after reset release, with no gap across the wrap.
